// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: main + skid entry, valid/ready handshake, flush-to-bubble.
// Optional performance counters are built only when STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  BubbleCount
);

  // Handshake: a transfer happens on a rising Clock edge where valid and ready are both 1.
  // In_Ready and Out_Valid are decoded from the registered state only, so neither
  // depends combinationally on the opposite side of the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;

  logic                w_acc;
  logic                w_rel;
  logic                w_load_main_in;
  logic                w_load_main_skid;
  logic                w_load_skid;

  assign Out_Valid = (r_state != ST_EMPTY);
  assign In_Ready  = (r_state != ST_FULL);
  assign w_acc     = In_Valid & In_Ready;
  assign w_rel     = Out_Valid & Out_Ready;

  // Bubbles must never leak control bits such as RegWrite or MemWrite downstream.
  assign Out_Ctrl  = Out_Valid ? r_main_ctrl : '0;
  assign Out_Data  = r_main_data;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_nxt    = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_acc && !w_rel) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (!w_acc && w_rel) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_acc && w_rel) begin
          w_load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_rel) begin
          w_state_nxt      = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    // Flush squashes everything held and anything offered this cycle.
    if (Flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main_in) begin
        r_main_ctrl <= In_Ctrl;
        r_main_data <= In_Data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= In_Ctrl;
        r_skid_data <= In_Data;
      end
    end
  end

`ifdef STAGE_PERF_CNT_EN
  // Saturating counters; only Reset clears them, Flush leaves them alone.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (Out_Valid && !Out_Ready && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!Out_Valid && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign StallCount  = r_stall_cnt;
  assign BubbleCount = r_bubble_cnt;
`else
  assign StallCount  = '0;
  assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, flush, counters.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 3;

  logic              Clock;
  logic              Reset;
  logic              Flush;
  logic              In_Valid;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl;
  logic [DATA_W-1:0] In_Data;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  BubbleCount;

  int n_checks;
  int n_errors;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Flush      (Flush),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Ctrl    (In_Ctrl),
    .In_Data    (In_Data),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Ctrl   (Out_Ctrl),
    .Out_Data   (Out_Data),
    .StallCount (StallCount),
    .BubbleCount(BubbleCount)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    In_Valid = v;
    In_Ctrl  = c;
    In_Data  = d;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                           input logic [DATA_W-1:0] d, input logic rdy);
    check({tag, "_valid"}, DATA_W'(Out_Valid), DATA_W'(v));
    check({tag, "_ctrl"},  DATA_W'(Out_Ctrl),  DATA_W'(c));
    check({tag, "_data"},  Out_Data,           d);
    check({tag, "_ready"}, DATA_W'(In_Ready),  DATA_W'(rdy));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    Reset     = 1'b1;
    Flush     = 1'b0;
    Out_Ready = 1'b0;
    drive(1'b1, 8'hFF, 96'h55);

    // 1: reset held two cycles with In_Valid=1
    tick();
    tick();
    check_out("reset", 1'b0, 8'h00, 96'h0, 1'b1);
    check("reset_stall",  DATA_W'(StallCount),  96'h0);
    check("reset_bubble", DATA_W'(BubbleCount), 96'h0);
    Reset = 1'b0;
    drive(1'b0, 8'h00, 96'h0);

    // 2: stream 1..8 with Out_Ready=1, one entry per cycle
    Out_Ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'h81, DATA_W'(i));
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, 8'h81, DATA_W'(i), 1'b1);
    end
    drive(1'b0, 8'h00, 96'h0);
    tick();
    check_out("drain", 1'b0, 8'h00, 96'h8, 1'b1);

    // 3: backpressure with A, B, C
    Out_Ready = 1'b0;
    drive(1'b1, 8'h11, 96'hA);
    tick();
    check_out("bp_a", 1'b1, 8'h11, 96'hA, 1'b1);
    drive(1'b1, 8'h22, 96'hB);
    tick();
    check_out("bp_b", 1'b1, 8'h11, 96'hA, 1'b0);
    drive(1'b1, 8'h33, 96'hC);
    tick();
    check_out("bp_hold", 1'b1, 8'h11, 96'hA, 1'b0);
    Out_Ready = 1'b1;
    tick();
    check_out("bp_out_b", 1'b1, 8'h22, 96'hB, 1'b1);
    tick();
    check_out("bp_out_c", 1'b1, 8'h33, 96'hC, 1'b1);
    drive(1'b0, 8'h00, 96'h0);
    tick();
    check_out("bp_empty", 1'b0, 8'h00, 96'hC, 1'b1);

    // 5: acc & rel together in ONE keeps ONE and replaces main
    Out_Ready = 1'b0;
    drive(1'b1, 8'h44, 96'hE);
    tick();
    check_out("one_e", 1'b1, 8'h44, 96'hE, 1'b1);
    Out_Ready = 1'b1;
    drive(1'b1, 8'h55, 96'hF);
    tick();
    check_out("one_f", 1'b1, 8'h55, 96'hF, 1'b1);

    // 4: fill to FULL, then flush while D is offered
    Out_Ready = 1'b0;
    drive(1'b1, 8'h66, 96'h6);
    tick();
    check_out("full", 1'b1, 8'h55, 96'hF, 1'b0);
    drive(1'b1, 8'h77, 96'hD);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check_out("flush", 1'b0, 8'h00, 96'hF, 1'b1);
    drive(1'b0, 8'h00, 96'h0);
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("post_flush%0d", i), 1'b0, 8'h00, 96'hF, 1'b1);
    end

    // 6: counters; 10 stall cycles saturate a 3-bit counter, Flush leaves them alone
    Out_Ready = 1'b0;
    drive(1'b1, 8'h99, 96'h123);
    tick();
    drive(1'b0, 8'h00, 96'h0);
    for (int i = 0; i < 10; i++) tick();
    check_out("stall_hold", 1'b1, 8'h99, 96'h123, 1'b1);
`ifdef STAGE_PERF_CNT_EN
    check("stall_sat",  DATA_W'(StallCount),  96'h7);
    check("bubble_sat", DATA_W'(BubbleCount), 96'h7);
`else
    check("stall_tied",  DATA_W'(StallCount),  96'h0);
    check("bubble_tied", DATA_W'(BubbleCount), 96'h0);
`endif
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check_out("flush2", 1'b0, 8'h00, 96'h123, 1'b1);
`ifdef STAGE_PERF_CNT_EN
    check("stall_after_flush",  DATA_W'(StallCount),  96'h7);
    check("bubble_after_flush", DATA_W'(BubbleCount), 96'h7);
`else
    check("stall_after_flush",  DATA_W'(StallCount),  96'h0);
    check("bubble_after_flush", DATA_W'(BubbleCount), 96'h0);
`endif

    // reset mid-transfer discards the held entry and clears counters
    Out_Ready = 1'b0;
    drive(1'b1, 8'hAA, 96'h456);
    tick();
    check_out("pre_reset", 1'b1, 8'hAA, 96'h456, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1'b0, 8'h00, 96'h0);
    check_out("mid_reset", 1'b0, 8'h00, 96'h0, 1'b1);
    check("mid_reset_stall",  DATA_W'(StallCount),  96'h0);
    check("mid_reset_bubble", DATA_W'(BubbleCount), 96'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
